// File: rtl/pos_btn_pkg.sv
// pos_btn_pkg: shared button indices and auto-repeat FSM encoding
package pos_btn_pkg;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronize, debounce and auto-repeat a single normalized button
module btn_debounce
  import pos_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed,
  output logic level,
  output logic req
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(max_int(REPEAT_DLY, REPEAT_RATE) + 1);
  localparam bit RPT_EN = REPEAT_DLY != 0;
  localparam logic [DW-1:0] D_END = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] H_END = RW'(RPT_EN ? REPEAT_DLY - 1 : 0);
  localparam logic [RW-1:0] R_END = RW'(REPEAT_RATE - 1);
  logic [1:0] sync;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  rpt_state_t state;
  logic hold_hit, rate_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync <= {sync[0], pressed};
      if (sync[1] == level) dcnt <= '0;
      else if (dcnt == D_END) begin
        level <= ~level;
        dcnt  <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  // IDLE with level high is exactly the cycle after the debounced rising edge
  always_comb begin
    hold_hit = RPT_EN && rcnt == H_END;
    rate_hit = rcnt == R_END;
    req = level && (state == IDLE || (state == HOLD && hold_hit) || (state == RPT && rate_hit));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
    end else if (!level) begin
      state <= IDLE;
      rcnt  <= '0;
    end else
      case (state)
        IDLE: begin
          state <= HOLD;
          rcnt  <= '0;
        end
        HOLD:
          if (hold_hit) begin
            state <= RPT;
            rcnt  <= '0;
          end else rcnt <= RPT_EN ? rcnt + 1'b1 : '0;
        RPT: rcnt <= rate_hit ? '0 : rcnt + 1'b1;
        default: begin
          state <= IDLE;
          rcnt  <= '0;
        end
      endcase
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: per-button conditioning plus lowest-index single-pulse arbitration
module btn_pulse_gen
  import pos_btn_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level
);
  logic [NUM_BTN-1:0] pressed, req;
  assign pressed = ACTIVE_LOW != 0 ? ~btn_raw : btn_raw;
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .pressed(pressed[g]),
      .level  (btn_level[g]),
      .req    (req[g])
    );
  end
  // losing requests are dropped, never queued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) btn_pulse <= '0;
    else btn_pulse <= req & (~req + 1'b1);
endmodule
